// File: rtl/pid_seq_pkg.sv
// Shared types, widths and default tuning values for the PID move sequencer.
package pid_seq_pkg;

  localparam int FRWRD_W = 10;
  localparam int ERR_W   = 12;
  localparam int CNT_W   = 6;

  localparam logic [FRWRD_W-1:0] FRWRD_INC_DEF      = 10'd6;
  localparam logic [FRWRD_W-1:0] MAX_FRWRD_DEF      = 10'h2A0;
  localparam logic [ERR_W-1:0]   ERR_THRESH_DEF     = 12'd44;
  localparam int                 PULSES_PER_SQR_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    RAMP  = 3'd2,
    DECEL = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Magnitude of a signed heading error, one bit wider so -2048 becomes +2048
  // and can never look like a small error.
  function automatic logic [ERR_W:0] err_abs(input logic [ERR_W-1:0] e);
    logic [ERR_W:0] ext;
    ext = {e[ERR_W-1], e};
    return e[ERR_W-1] ? (~ext + 1'b1) : ext;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector: pulses for one cycle when din goes 0->1.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q;

  // Remember the previous sample of din.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= din;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/pid_move_seq.sv
// Move sequencer ahead of the PID: turn to heading, ramp speed up, count
// centre-line squares, ramp down, then report done.
//
// Handshake: a move transfers on a cycle where mv_vld & mv_rdy are both high.
// mv_rdy is high only in IDLE; mv_vld in any other state is ignored and not
// queued, so the requester must hold mv_vld until it sees mv_rdy.
module pid_move_seq
  import pid_seq_pkg::*;
#(
  parameter logic [FRWRD_W-1:0] FRWRD_INC      = FRWRD_INC_DEF,
  parameter logic [FRWRD_W-1:0] MAX_FRWRD      = MAX_FRWRD_DEF,
  parameter logic [ERR_W-1:0]   ERR_THRESH     = ERR_THRESH_DEF,
  parameter int                 PULSES_PER_SQR = PULSES_PER_SQR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mv_vld,
  output logic               mv_rdy,
  input  logic [ERR_W-1:0]   mv_hdg,
  input  logic [3:0]         mv_sqrs,
  input  logic [ERR_W-1:0]   heading,
  input  logic               heading_rdy,
  input  logic               cntrIR,
  output logic               moving,
  output logic               err_vld,
  output logic [ERR_W-1:0]   error,
  output logic [FRWRD_W-1:0] frwrd,
  output logic               mv_done,
  output seq_state_t         dbg_state
);

  seq_state_t         state_q, state_d;
  logic [ERR_W-1:0]   hdg_q;
  logic [3:0]         sqrs_q;
  logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ir_rise;
  logic               accept;

  logic [ERR_W:0]     err_mag;
  logic               on_heading;
  logic [CNT_W-1:0]   cnt_target;
  logic [CNT_W-1:0]   cnt_inc;
  logic [FRWRD_W:0]   frwrd_sum;
  logic [FRWRD_W-1:0] frwrd_up;
  logic [FRWRD_W-1:0] frwrd_dn;
  logic [FRWRD_W-1:0] dec_step;

  rise_det u_ir_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cntrIR),
    .rise  (ir_rise)
  );

  assign error      = heading - hdg_q;
  assign err_mag    = err_abs(error);
  assign on_heading = err_mag < {1'b0, ERR_THRESH};

  assign cnt_target = CNT_W'(PULSES_PER_SQR) * {2'b00, sqrs_q};
  assign cnt_inc    = cnt_q + {{(CNT_W-1){1'b0}}, ir_rise};

  // Saturating speed steps: ceiling on the way up, floor of 0 on the way down.
  assign frwrd_sum = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
  assign frwrd_up  = (frwrd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_sum[FRWRD_W-1:0];
  assign dec_step  = {FRWRD_INC[FRWRD_W-2:0], 1'b0};
  assign frwrd_dn  = (frwrd_q > dec_step) ? (frwrd_q - dec_step) : '0;

  assign accept = (state_q == IDLE) & mv_vld;

  // Next-state, speed and pulse-count logic.
  always_comb begin
    state_d = state_q;
    frwrd_d = frwrd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        frwrd_d = '0;
        if (mv_vld) begin
          state_d = TURN;
          cnt_d   = '0;
        end
      end
      TURN: begin
        if (heading_rdy && on_heading)
          state_d = (sqrs_q != 4'd0) ? RAMP : DONE;
      end
      RAMP: begin
        cnt_d = cnt_inc;
        // Reaching the square count wins over a speed step in the same cycle.
        if (cnt_inc == cnt_target) state_d = DECEL;
        else if (heading_rdy)      frwrd_d = frwrd_up;
      end
      DECEL: begin
        if (heading_rdy) begin
          if (frwrd_q == '0) state_d = DONE;
          else               frwrd_d = frwrd_dn;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, speed, pulse count and latched move registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frwrd_q <= '0;
      cnt_q   <= '0;
      hdg_q   <= '0;
      sqrs_q  <= '0;
    end else begin
      state_q <= state_d;
      frwrd_q <= frwrd_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hdg_q  <= mv_hdg;
        sqrs_q <= mv_sqrs;
      end
    end
  end

  assign mv_rdy    = (state_q == IDLE);
  assign moving    = (state_q != IDLE);
  assign err_vld   = heading_rdy & moving;
  assign mv_done   = (state_q == DONE);
  assign frwrd     = frwrd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pid_move_seq.sv
// Self-checking bench for the PID move sequencer.
module tb_pid_move_seq;
  import pid_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv_vld;
  logic        mv_rdy;
  logic [11:0] mv_hdg;
  logic [3:0]  mv_sqrs;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic        mv_done;
  seq_state_t  dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  logic [9:0] b_frwrd;
  logic [9:0] exp_q[$];

  pid_move_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mv_vld      (mv_vld),
    .mv_rdy      (mv_rdy),
    .mv_hdg      (mv_hdg),
    .mv_sqrs     (mv_sqrs),
    .heading     (heading),
    .heading_rdy (heading_rdy),
    .cntrIR      (cntrIR),
    .moving      (moving),
    .err_vld     (err_vld),
    .error       (error),
    .frwrd       (frwrd),
    .mv_done     (mv_done),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  // Acceptances are counted from the handshake seen just before the edge.
  task automatic cyc();
    if (mv_vld && mv_rdy) n_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [11:0] hd);
    heading     = hd;
    heading_rdy = 1'b1;
    cyc();
    heading_rdy = 1'b0;
  endtask

  task automatic strobe_chk(input string tag, input logic [11:0] hd, input logic [11:0] exp_err);
    heading     = hd;
    heading_rdy = 1'b1;
    #1;
    check({tag, "_vld"}, 32'(err_vld), 32'd1);
    check({tag, "_err"}, 32'(error), 32'(exp_err));
    cyc();
    heading_rdy = 1'b0;
  endtask

  task automatic start_move(input logic [11:0] hdg, input logic [3:0] sqrs);
    mv_hdg  = hdg;
    mv_sqrs = sqrs;
    mv_vld  = 1'b1;
    check("rdy_before_move", 32'(mv_rdy), 32'd1);
    cyc();
    mv_vld  = 1'b0;
    b_frwrd = '0;
    check("moving_after_accept", 32'(moving), 32'd1);
    check("turn_after_accept", 32'(dbg_state), 32'(TURN));
  endtask

  // Scoreboard: predict frwrd for one accelerating strobe, then compare.
  task automatic ramp_step(input logic [11:0] hd);
    logic [10:0] s;
    s       = {1'b0, b_frwrd} + 11'd6;
    b_frwrd = (s > 11'h2A0) ? 10'h2A0 : s[9:0];
    exp_q.push_back(b_frwrd);
    strobe(hd);
    check("ramp_frwrd", 32'(frwrd), 32'(exp_q.pop_front()));
  endtask

  task automatic decel_step(input logic [11:0] hd);
    b_frwrd = (b_frwrd > 10'd12) ? b_frwrd - 10'd12 : 10'd0;
    exp_q.push_back(b_frwrd);
    strobe(hd);
    check("decel_frwrd", 32'(frwrd), 32'(exp_q.pop_front()));
  endtask

  task automatic ir_pulse();
    cntrIR = 1'b1;
    cyc();
    cntrIR = 1'b0;
    cyc();
  endtask

  // Keep strobing heading until the move completes; count done pulses,
  // track peak speed and confirm the sequencer is idle right after done.
  task automatic wait_done(input string tag, input logic [11:0] hd, input int budget,
                           input logic [9:0] exp_peak);
    int   pulses;
    logic after_done;
    logic [9:0] peak;
    pulses     = 0;
    after_done = 1'b0;
    peak       = frwrd;
    for (int i = 0; i < budget; i++) begin
      heading     = hd;
      heading_rdy = (i % 2 == 0);
      cyc();
      heading_rdy = 1'b0;
      if (frwrd > peak) peak = frwrd;
      if (after_done) begin
        check({tag, "_moving_after_done"}, 32'(moving), 32'd0);
        check({tag, "_rdy_after_done"}, 32'(mv_rdy), 32'd1);
        after_done = 1'b0;
      end
      if (mv_done) begin
        pulses++;
        after_done = 1'b1;
        check({tag, "_frwrd_at_done"}, 32'(frwrd), 32'd0);
      end
    end
    check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_peak_frwrd"}, 32'(peak), 32'(exp_peak));
  endtask

  initial begin
    rst_n       = 1'b0;
    mv_vld      = 1'b0;
    mv_hdg      = '0;
    mv_sqrs     = '0;
    heading     = '0;
    heading_rdy = 1'b0;
    cntrIR      = 1'b0;
    b_frwrd     = '0;

    // Reset for three cycles, then release.
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_rdy", 32'(mv_rdy), 32'd1);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_frwrd", 32'(frwrd), 32'd0);
    check("rst_done", 32'(mv_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Turn hold, turn exit, ramp to saturation, decel to zero.
    start_move(12'h000, 4'd1);
    strobe_chk("turn_hold", 12'h3FF, 12'h3FF);
    check("turn_hold_state", 32'(dbg_state), 32'(TURN));
    check("turn_hold_frwrd", 32'(frwrd), 32'd0);
    strobe_chk("turn_exit", 12'h010, 12'h010);
    check("ramp_entered", 32'(dbg_state), 32'(RAMP));
    for (int i = 0; i < 200; i++) ramp_step(12'h010);
    check("ramp_sat", 32'(frwrd), 32'h2A0);
    ir_pulse();
    check("one_edge_still_ramp", 32'(dbg_state), 32'(RAMP));
    cntrIR = 1'b1;
    cyc();
    cntrIR = 1'b0;
    check("decel_on_edge", 32'(dbg_state), 32'(DECEL));
    check("decel_hold_frwrd", 32'(frwrd), 32'h2A0);
    for (int i = 0; i < 100 && b_frwrd != 10'd0; i++) decel_step(12'h010);
    check("decel_floor", 32'(frwrd), 32'd0);
    wait_done("move1", 12'h010, 20, 10'd0);

    // Turn-only move: -2048 never passes, threshold boundary holds, -43 exits.
    start_move(12'h100, 4'd0);
    for (int i = 0; i < 3; i++) strobe_chk("err_min", 12'h900, 12'h800);
    check("err_min_state", 32'(dbg_state), 32'(TURN));
    strobe_chk("err_44", 12'h12C, 12'h02C);
    check("err_44_state", 32'(dbg_state), 32'(TURN));
    strobe_chk("err_m43", 12'h0D5, 12'hFD5);
    check("turn_only_done", 32'(mv_done), 32'd1);
    check("turn_only_frwrd", 32'(frwrd), 32'd0);
    cyc();
    check("turn_only_idle", 32'(moving), 32'd0);
    check("turn_only_done_once", 32'(mv_done), 32'd0);

    // Heading wrap: 0x800 - 0x7FF = 0x001.
    start_move(12'h7FF, 4'd0);
    strobe_chk("wrap", 12'h800, 12'h001);
    check("wrap_done", 32'(mv_done), 32'd1);
    cyc();

    // mv_vld held through a whole move: one acceptance, next right after done.
    n_acc   = 0;
    mv_hdg  = 12'h000;
    mv_sqrs = 4'd1;
    mv_vld  = 1'b1;
    b_frwrd = '0;
    cyc();
    check("held_turn", 32'(dbg_state), 32'(TURN));
    strobe(12'h000);
    ramp_step(12'h000);
    ir_pulse();
    ir_pulse();
    check("held_decel", 32'(dbg_state), 32'(DECEL));
    decel_step(12'h000);
    strobe(12'h000);
    check("held_done", 32'(mv_done), 32'd1);
    check("held_one_accept", 32'(n_acc), 32'd1);
    cyc();
    check("held_idle_rdy", 32'(mv_rdy), 32'd1);
    check("held_idle_moving", 32'(moving), 32'd0);
    cyc();
    mv_vld = 1'b0;
    check("held_second_accept", 32'(n_acc), 32'd2);
    check("held_second_turn", 32'(dbg_state), 32'(TURN));

    // Reset in the middle of a ramp.
    b_frwrd = '0;
    strobe(12'h000);
    for (int i = 0; i < 3; i++) ramp_step(12'h000);
    rst_n = 1'b0;
    cyc();
    check("midrst_rdy", 32'(mv_rdy), 32'd1);
    check("midrst_moving", 32'(moving), 32'd0);
    check("midrst_frwrd", 32'(frwrd), 32'd0);
    check("midrst_done", 32'(mv_done), 32'd0);
    check("midrst_errvld", 32'(err_vld), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    cyc();

    // After reset the pulse count starts fresh: sqrs=2 needs four edges.
    start_move(12'h000, 4'd2);
    strobe(12'h000);
    for (int i = 0; i < 5; i++) ramp_step(12'h000);
    for (int i = 0; i < 3; i++) ir_pulse();
    check("three_edges_ramp", 32'(dbg_state), 32'(RAMP));
    ir_pulse();
    check("four_edges_decel", 32'(dbg_state), 32'(DECEL));
    for (int i = 0; i < 10 && b_frwrd != 10'd0; i++) decel_step(12'h000);
    wait_done("move2", 12'h000, 20, 10'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
